// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch controller.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Word-align an address by clearing its two low bits.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, instr} entries. Entry e0 is always the head.
// Flush beats push and pop. The caller never pushes into a full buffer
// without a same-cycle pop, and never pops an empty one.
module fetch_buf
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t din,
   output logic [1:0]   count,
   output logic         head_valid,
   output fetch_entry_t head
);

   fetch_entry_t e0;
   fetch_entry_t e1;

   // Occupancy counter; reset and flush both empty the buffer.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; the head shifts forward on pop so order is preserved.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) e0 <= din;
               else               e1 <= din;
            end
            2'b01: e0 <= e1;
            2'b11: begin
               if (count == 2'd2) begin
                  e0 <= e1;
                  e1 <= din;
               end else begin
                  e0 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   // Head view: NOP at pc 0 whenever the buffer is empty.
   always_comb begin
      head_valid = (count != 2'd0);
      head.pc    = 32'h0;
      head.instr = NOP_INSTR;
      if (head_valid) head = e0;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches one word per cycle from
// a combinational-read memory into a 2-entry buffer, flushes on redirect and
// stops fetching once an EBREAK has been captured.
//
// Decode handshake: out_valid means the head entry on out_instr/out_pc is
// meaningful; an entry is transferred on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// head holds steady. A redirect in the same cycle cancels that transfer.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted
);

   localparam logic [0:0] ST_FETCH = FETCH;
   localparam logic [0:0] ST_HALT  = HALT;

   logic [0:0]   state;
   logic [31:0]  fetch_pc;
   logic [1:0]   count;
   logic         head_valid;
   fetch_entry_t head;
   fetch_entry_t din;
   logic         push;
   logic         pop;

   // Handshake and push qualification; redirect suppresses any push.
   always_comb begin
      pop       = head_valid && out_ready;
      push      = (state == ST_FETCH) && !redirect_valid
                  && ((count < 2'd2) || pop);
      din.pc    = fetch_pc;
      din.instr = imem_rdata;
   end

   // PC and FSM: redirect wins over push/halt; EBREAK is pushed, then halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         state    <= ST_FETCH;
      end else if (redirect_valid) begin
         fetch_pc <= align_pc(redirect_pc);
         state    <= ST_FETCH;
      end else if (push) begin
         fetch_pc <= fetch_pc + 32'd4;
         if (imem_rdata == EBREAK_INSTR) state <= ST_HALT;
      end
   end

   fetch_buf u_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .pop        (pop),
      .din        (din),
      .count      (count),
      .head_valid (head_valid),
      .head       (head)
   );

   // Output view; halted mirrors the FSM state for observability.
   always_comb begin
      imem_addr = fetch_pc;
      out_valid = head_valid;
      out_instr = head.instr;
      out_pc    = head.pc;
      halted    = (state == ST_HALT);
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a small combinational memory model,
// one task per scenario, and an expected queue of {pc, instr} entries.
module tb_fetch_ctrl;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;

   logic [31:0] mem [64];
   logic [63:0] exp_q [$];
   logic [63:0] exp;
   int          n_cmp;
   int          n_err;

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted)
   );

   // Clock and memory model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb imem_rdata = mem[imem_addr[7:2]];

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no summary, required summary");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic mem_nop();
      for (int i = 0; i < 64; i++) mem[i] = NOP;
   endtask

   task automatic mem_distinct();
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
   endtask

   task automatic do_reset();
      exp_q.delete();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      mem_distinct();
      do_reset();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
      n_cmp++; if (out_instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h required %h", out_instr, NOP); end
      n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h required 0", out_pc); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b required 0", halted); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
   endtask

   task automatic test_stream();
      mem_nop();
      mem[0] = 32'h0050_0093; mem[3] = 32'h00A0_0113;
      do_reset();
      exp_q.push_back({32'h0, 32'h0050_0093});
      exp_q.push_back({32'h4, NOP});
      exp_q.push_back({32'h8, NOP});
      exp_q.push_back({32'hC, 32'h00A0_0113});
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL stream_valid[%0d]: got %b required 1", i, out_valid);
         end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({out_pc, out_instr} !== exp) begin
               n_err++; $display("FAIL stream_entry[%0d]: got %h/%h required %h/%h", i, out_pc, out_instr, exp[63:32], exp[31:0]);
            end
         end
      end
   endtask

   task automatic test_stall();
      mem_distinct();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (imem_addr !== ((i == 0) ? 32'h4 : 32'h8)) begin
            n_err++; $display("FAIL stall_addr[%0d]: got %h required %h", i, imem_addr, (i == 0) ? 32'h4 : 32'h8);
         end
         n_cmp++;
         if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            n_err++; $display("FAIL stall_head[%0d]: got %b/%h required 1/0", i, out_valid, out_pc);
         end
      end
      for (int i = 0; i < 3; i++) exp_q.push_back({32'(4 * i), mem[i]});
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL release_valid[%0d]: got %b required 1", i, out_valid);
         end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({out_pc, out_instr} !== exp) begin
               n_err++; $display("FAIL release_entry[%0d]: got %h/%h required %h/%h", i, out_pc, out_instr, exp[63:32], exp[31:0]);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_redirect_full();
      mem_distinct();
      do_reset();
      repeat (2) @(posedge clk);
      #1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0022; out_ready = 1'b1;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble: got %b required 0", out_valid); end
      n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL redir_addr: got %h required 20", imem_addr); end
      for (int i = 0; i < 3; i++) exp_q.push_back({32'h20 + 32'(4 * i), mem[8 + i]});
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL redir_valid[%0d]: got %b required 1", i, out_valid);
         end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({out_pc, out_instr} !== exp) begin
               n_err++; $display("FAIL redir_entry[%0d]: got %h/%h required %h/%h", i, out_pc, out_instr, exp[63:32], exp[31:0]);
            end
         end
      end
   endtask

   task automatic test_halt();
      mem_nop();
      mem[2] = EBREAK;
      do_reset();
      for (int i = 0; i < 3; i++) exp_q.push_back({32'(4 * i), mem[i]});
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (halted !== (i == 2)) begin n_err++; $display("FAIL halt_flag[%0d]: got %b required %b", i, halted, i == 2); end
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL halt_valid[%0d]: got %b required 1", i, out_valid);
         end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({out_pc, out_instr} !== exp) begin
               n_err++; $display("FAIL halt_entry[%0d]: got %h/%h required %h/%h", i, out_pc, out_instr, exp[63:32], exp[31:0]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'hC) begin
            n_err++; $display("FAIL halted_idle[%0d]: got v=%b h=%b a=%h required v=0 h=1 a=c", i, out_valid, halted, imem_addr);
         end
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL unhalt: got %b required 0", halted); end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
         n_err++; $display("FAIL restart: got %b/%h required 1/0", out_valid, out_pc);
      end
   endtask

   task automatic test_wrap();
      mem_distinct();
      do_reset();
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h required fffffffc", imem_addr); end
      exp_q.push_back({32'hFFFF_FFFC, mem[63]});
      exp_q.push_back({32'h0, mem[0]});
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL wrap_valid[%0d]: got %b required 1", i, out_valid);
         end else begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({out_pc, out_instr} !== exp) begin
               n_err++; $display("FAIL wrap_entry[%0d]: got %h/%h required %h/%h", i, out_pc, out_instr, exp[63:32], exp[31:0]);
            end
         end
      end
   endtask

   task automatic test_rst_override();
      mem_distinct();
      do_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0) begin
         n_err++; $display("FAIL rst_override: got v=%b a=%h h=%b required v=0 a=0 h=0", out_valid, imem_addr, halted);
      end
      rst = 1'b0; redirect_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem[0]) begin
         n_err++; $display("FAIL rst_refetch: got %b/%h/%h required 1/0/%h", out_valid, out_pc, out_instr, mem[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] nxt;
      mem_distinct();
      do_reset();
      nxt = 32'h0;
      for (int i = 0; i < 40; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            exp_q.push_back({nxt, mem[nxt[7:2]]});
            nxt = nxt + 32'd4;
            exp = exp_q.pop_front();
            n_cmp++;
            if ({out_pc, out_instr} !== exp) begin
               n_err++; $display("FAIL b2b_entry[%0d]: got %h/%h required %h/%h", i, out_pc, out_instr, exp[63:32], exp[31:0]);
            end
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b required 1", out_valid); end
   endtask

   // Sequencer and final report
   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      mem_nop();
      test_reset();
      test_stream();
      test_stall();
      test_redirect_full();
      test_halt();
      test_wrap();
      test_rst_override();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
